// File: rtl/bcd_convert_sched.sv
// Shared iterative binary-to-BCD converter (double-dabble) serving two requesters
// through a round-robin req/ack front end and a tagged, strobed result register.
module bcd_convert_sched #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [W-1:0]   din0,
    output logic           ack0,
    input  logic           req1,
    input  logic [W-1:0]   din1,
    output logic           ack1,
    output logic           busy,
    output logic           valid,
    output logic           ch,
    output logic [4*D-1:0] bcd
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sr_q, sr_d;
    logic [4*D-1:0] acc_q, acc_d, acc_adj, acc_sh;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_q, last_d;
    logic           ack0_q, ack0_d, ack1_q, ack1_d;
    logic           busy_q, busy_d, valid_q, valid_d, ch_q, ch_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic           grant;

    // Per-digit add-3 correction ahead of the shift; digits never carry into each other.
    for (genvar k = 0; k < D; k++) begin : g_dig
        assign acc_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3
                                                              : acc_q[4*k +: 4];
    end

    assign acc_sh = {acc_adj[4*D-2:0], sr_q[W-1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
        valid_d = 1'b0;
        ch_d    = ch_q;
        bcd_d   = bcd_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whichever channel was not served last.
                    grant   = (req0 && req1) ? ~last_q : req1;
                    sr_d    = grant ? din1 : din0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = grant;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    bcd_d   = acc_sh;
                    ch_d    = last_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ch_q    <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            bcd_q   <= bcd_d;
        end
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign ch    = ch_q;
    assign bcd   = bcd_q;
endmodule

// File: tb/tb_bcd_convert_sched.sv
// Directed bench for bcd_convert_sched: an 8-bit/3-digit build and a 16-bit/5-digit build.
module tb_bcd_convert_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, ack0, ack1, busy, valid, ch;
    logic [7:0]  din0, din1;
    logic [11:0] bcd;
    logic        r16_req0;
    logic [15:0] r16_din0;
    logic        a16_0, a16_1, b16, v16, c16;
    logic [19:0] bcd16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bcd_convert_sched #(.W(8), .D(3)) dut (
        .clk(clk), .rst(rst), .req0(req0), .din0(din0), .ack0(ack0),
        .req1(req1), .din1(din1), .ack1(ack1), .busy(busy), .valid(valid),
        .ch(ch), .bcd(bcd)
    );

    bcd_convert_sched #(.W(16), .D(5)) dut16 (
        .clk(clk), .rst(rst), .req0(r16_req0), .din0(r16_din0), .ack0(a16_0),
        .req1(1'b0), .din1(16'd0), .ack1(a16_1), .busy(b16), .valid(v16),
        .ch(c16), .bcd(bcd16)
    );

    function automatic logic [19:0] model(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full handshake on one channel; reports what was seen, the checking is done by callers.
    task automatic convert(input logic c, input logic [7:0] v, output logic ok, output logic ach,
                           output logic [11:0] rb, output logic rc, output int lat,
                           output int bcnt, output logic busy_at_valid);
        ok = 1'b0; ach = 1'b0; rb = '0; rc = 1'b0; lat = 0; bcnt = 0; busy_at_valid = 1'b0;
        if (c) begin req1 = 1'b1; din1 = v; end
        else   begin req0 = 1'b1; din0 = v; end
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ack0 || ack1) begin ok = 1'b1; ach = ack1; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        din0 = ~v;  din1 = ~v;
        if (!ok) return;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            tick;
            lat++;
            if (valid) begin ok = 1'b1; rb = bcd; rc = ch; busy_at_valid = busy; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
        r16_req0 = 1'b0; r16_din0 = '0;
        tick; tick;
        checks++;
        if ({ack0, ack1, busy, valid, ch, bcd} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero", {ack0, ack1, busy, valid, ch, bcd});
        end
        checks++;
        if ({a16_0, a16_1, b16, v16, c16, bcd16} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs16: got %h required 0", {a16_0, a16_1, b16, v16, c16, bcd16});
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        logic ok, ach, rc, bav; logic [11:0] rb; int lat, bcnt;
        convert(1'b0, 8'd255, ok, ach, rb, rc, lat, bcnt, bav);
        checks++;
        if (!ok || ach !== 1'b0) begin errors++; $display("FAIL single_handshake: ok=%b ack_ch=%b required ok=1 ack_ch=0", ok, ach); end
        checks++;
        if (lat != 8) begin errors++; $display("FAIL single_latency: got %0d edges required 8", lat); end
        checks++;
        if (bcnt != 8 || bav !== 1'b0) begin errors++; $display("FAIL single_busy: got %0d cycles busy_at_valid=%b required 8 and 0", bcnt, bav); end
        checks++;
        if (rb !== 12'h255 || rc !== 1'b0) begin errors++; $display("FAIL single_result: got bcd=%h ch=%b required 255 ch=0", rb, rc); end
    endtask

    task automatic test_alternate;
        logic       seq [4];
        logic [12:0] res [4];
        int na, nv;
        logic both;
        na = 0; nv = 0; both = 1'b0;
        rst = 1'b1; #2; rst = 1'b0;
        tick;
        din0 = 8'd0; din1 = 8'd128; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 100 && nv < 4; i++) begin
            tick;
            if (ack0 && ack1) both = 1'b1;
            if ((ack0 || ack1) && na < 4) begin
                seq[na] = ack1; na++;
                if (na == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (valid) begin res[nv] = {ch, bcd}; nv++; end
        end
        checks++;
        if (na != 4 || nv != 4 || both) begin errors++; $display("FAIL alt_counts: acks=%0d valids=%0d both=%b required 4 4 0", na, nv, both); end
        else begin
            checks++;
            if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b0101) begin
                errors++; $display("FAIL alt_order: got %b%b%b%b required 0101", seq[0], seq[1], seq[2], seq[3]);
            end
            checks++;
            if (res[0] !== {1'b0, 12'h000} || res[1] !== {1'b1, 12'h128}) begin
                errors++; $display("FAIL alt_results: got %h %h required 0000 1128", res[0], res[1]);
            end
        end
    endtask

    task automatic test_sweep;
        logic ok, ach, rc, bav; logic [11:0] rb; int lat, bcnt;
        for (int v = 0; v < 256; v++) begin
            convert(1'b1, 8'(v), ok, ach, rb, rc, lat, bcnt, bav);
            checks++;
            if (!ok || ach !== 1'b1 || lat != 8 || rb !== model(v)[11:0] || rc !== 1'b1) begin
                errors++;
                $display("FAIL sweep_%0d: ok=%b lat=%0d bcd=%h ch=%b required lat=8 bcd=%h ch=1", v, ok, lat, rb, rc, model(v)[11:0]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic ok, ach, rc, bav, got_ack, stray; logic [11:0] rb; int lat, bcnt;
        got_ack = 1'b0; stray = 1'b0;
        req0 = 1'b1; din0 = 8'd99;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (ack0) begin got_ack = 1'b1; break; end
        end
        req0 = 1'b0;
        checks++;
        if (!got_ack) begin errors++; $display("FAIL mid_ack: no ack0 seen, required ack0"); end
        tick; tick; tick;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, ack0, ack1, valid, bcd} !== 16'd0) begin
            errors++; $display("FAIL mid_reset_async: got busy=%b ack=%b%b valid=%b bcd=%h required all zero", busy, ack0, ack1, valid, bcd);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin tick; if (valid) stray = 1'b1; end
        checks++;
        if (stray) begin errors++; $display("FAIL mid_no_valid: got a valid pulse after reset, required none"); end
        convert(1'b0, 8'd99, ok, ach, rb, rc, lat, bcnt, bav);
        checks++;
        if (!ok || rb !== 12'h099 || rc !== 1'b0) begin errors++; $display("FAIL mid_rerequest: ok=%b bcd=%h ch=%b required 099 ch=0", ok, rb, rc); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [4] = '{8'd5, 8'd77, 8'd200, 8'd31};
        int na, nv, cyc, prev;
        na = 0; nv = 0; cyc = 0; prev = 0;
        req0 = 1'b1; din0 = vals[0];
        for (int i = 0; i < 60; i++) begin
            tick;
            cyc++;
            if (ack0) begin
                if (na > 0) begin
                    checks++;
                    if (cyc - prev != 9) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d edges required 9", na, cyc - prev); end
                end
                prev = cyc;
                if (na < 4) din0 = ~vals[na];
                na++;
                if (na == 4) req0 = 1'b0;
            end
            if (valid) begin
                checks++;
                if (nv >= 4) begin errors++; $display("FAIL b2b_extra_valid: got valid #%0d required only 4", nv + 1); end
                else if (bcd !== model(vals[nv])[11:0] || ch !== 1'b0) begin
                    errors++; $display("FAIL b2b_result_%0d: got bcd=%h ch=%b required %h ch=0", nv, bcd, ch, model(vals[nv])[11:0]);
                end
                nv++;
                if (nv < 4) din0 = vals[nv];
            end
        end
        checks++;
        if (na != 4 || nv != 4) begin errors++; $display("FAIL b2b_counts: acks=%0d valids=%0d required 4 4", na, nv); end
    endtask

    task automatic test_w16;
        logic [15:0] vin [2] = '{16'd65535, 16'd10000};
        logic [19:0] exp [2] = '{20'h65535, 20'h10000};
        logic ok;
        int lat;
        for (int t = 0; t < 2; t++) begin
            ok = 1'b0; lat = 0;
            r16_req0 = 1'b1; r16_din0 = vin[t];
            for (int i = 0; i < 20; i++) begin tick; if (a16_0) begin ok = 1'b1; break; end end
            r16_req0 = 1'b0; r16_din0 = 16'h1234;
            if (ok) begin
                ok = 1'b0;
                for (int i = 0; i < 40; i++) begin tick; lat++; if (v16) begin ok = 1'b1; break; end end
            end
            checks++;
            if (!ok || lat != 16 || bcd16 !== exp[t] || c16 !== 1'b0) begin
                errors++; $display("FAIL w16_%0d: ok=%b lat=%0d bcd=%h required lat=16 bcd=%h", t, ok, lat, bcd16, exp[t]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_alternate;
        test_sweep;
        test_reset_mid;
        test_back_to_back;
        test_w16;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
